// File: rtl/conv_host_pkg.sv
// -----------------------------------------------------------------------------
// conv_host_pkg
// Shared constants and types for the convolution-engine memory host:
//   - data/address widths of the image, layer-0 and layer-1 storage
//   - csel bank-select codes
//   - host sequencing state enum
//   - write-counter widths and saturation limits
// -----------------------------------------------------------------------------
package conv_host_pkg;

    localparam int DW      = 20;  // signed 4.16 fixed point
    localparam int IMG_AW  = 12;  // 64x64 image / layer-0
    localparam int L1_AW   = 10;  // 32x32 layer-1

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    localparam int WCNT0_W = 13;
    localparam int WCNT1_W = 11;
    localparam logic [WCNT0_W-1:0] WCNT0_MAX = 13'h1FFF;
    localparam logic [WCNT1_W-1:0] WCNT1_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when csel addresses one of the two layer banks.
    function automatic logic csel_mapped(input logic [2:0] csel);
        return (csel == CSEL_L0) || (csel == CSEL_L1);
    endfunction

endpackage

// File: rtl/conv_host_bank.sv
// -----------------------------------------------------------------------------
// conv_host_bank
// Register-array storage bank: one synchronous write port and two
// asynchronous (zero-latency) read ports. A read of the address being
// written in the same cycle returns the old contents.
// Ports:
//   clk              clock, rising edge
//   we/waddr/wdata   write port
//   raddr_a/rdata_a  engine read port
//   raddr_b/rdata_b  dump read port
// Contents are intentionally never reset.
// -----------------------------------------------------------------------------
module conv_host_bank
    import conv_host_pkg::*;
#(
    parameter int BW = DW,
    parameter int AW = IMG_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [BW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [BW-1:0] rdata_b
);

    localparam int DEPTH = 1 << AW;

    logic [BW-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/conv_layer_host.sv
// -----------------------------------------------------------------------------
// conv_layer_host
// Responder side of the convolution engine's memory interface. Holds the
// 64x64 input image, the 64x64 layer-0 buffer and the 32x32 layer-1 buffer,
// answers engine reads/writes, sequences the ready/busy start handshake and
// counts layer writes made during a run.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   ld_we, ld_addr, ld_data, ld_last   image load interface
//   ready (out), busy (in)             start handshake
//   iaddr, idata                       image read (combinational)
//   cwr, caddr_wr, cdata_wr            layer write (csel bank)
//   crd, caddr_rd, cdata_rd            layer read (combinational, csel bank)
//   csel                               001 = layer 0, 011 = layer 1
//   dump_sel, dump_addr, dump_data     result readback (combinational)
//   done, wcnt0, wcnt1                 run status
// Optional build macro CONV_HOST_ERRCHK_EN adds a sticky 'err' output that
// flags unmapped csel accesses, layer-1 accesses with address bits [11:10]
// set, and a start timeout (2^16 cycles of ready without busy).
// -----------------------------------------------------------------------------
module conv_layer_host
    import conv_host_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_we,
    input  logic [IMG_AW-1:0]   ld_addr,
    input  logic [DW-1:0]       ld_data,
    input  logic                ld_last,
    output logic                ready,
    input  logic                busy,
    input  logic [IMG_AW-1:0]   iaddr,
    output logic [DW-1:0]       idata,
    input  logic                cwr,
    input  logic [IMG_AW-1:0]   caddr_wr,
    input  logic [DW-1:0]       cdata_wr,
    input  logic                crd,
    input  logic [IMG_AW-1:0]   caddr_rd,
    output logic [DW-1:0]       cdata_rd,
    input  logic [2:0]          csel,
    input  logic                dump_sel,
    input  logic [IMG_AW-1:0]   dump_addr,
    output logic [DW-1:0]       dump_data,
    output logic                done,
    output logic [WCNT0_W-1:0]  wcnt0,
    output logic [WCNT1_W-1:0]  wcnt1
`ifdef CONV_HOST_ERRCHK_EN
   ,output logic                err
`endif
);

    state_t               state_r;
    logic                 busy_q_r;
    logic                 ready_r;
    logic                 done_r;
    logic [WCNT0_W-1:0]   wcnt0_r;
    logic [WCNT1_W-1:0]   wcnt1_r;

    logic                 img_we_s;
    logic                 l0_we_s;
    logic                 l1_we_s;
    logic [DW-1:0]        l0_rd_s;
    logic [DW-1:0]        l1_rd_s;
    logic [DW-1:0]        l0_dump_s;
    logic [DW-1:0]        l1_dump_s;
    logic [DW-1:0]        img_dump_unused_s;

    // Image loads are accepted while loading and, for late patches, while armed.
    always_comb begin
        if (ld_we && ((state_r == LOAD) || (state_r == ARMED))) begin
            img_we_s = 1'b1;
        end else begin
            img_we_s = 1'b0;
        end
    end

    assign l0_we_s = cwr && (csel == CSEL_L0);
    assign l1_we_s = cwr && (csel == CSEL_L1);

    conv_host_bank #(.BW(DW), .AW(IMG_AW)) u_img (
        .clk     (clk),
        .we      (img_we_s),
        .waddr   (ld_addr),
        .wdata   (ld_data),
        .raddr_a (iaddr),
        .rdata_a (idata),
        .raddr_b ({IMG_AW{1'b0}}),
        .rdata_b (img_dump_unused_s)
    );

    conv_host_bank #(.BW(DW), .AW(IMG_AW)) u_l0 (
        .clk     (clk),
        .we      (l0_we_s),
        .waddr   (caddr_wr),
        .wdata   (cdata_wr),
        .raddr_a (caddr_rd),
        .rdata_a (l0_rd_s),
        .raddr_b (dump_addr),
        .rdata_b (l0_dump_s)
    );

    // Layer 1 only decodes the low address bits; [11:10] are ignored.
    conv_host_bank #(.BW(DW), .AW(L1_AW)) u_l1 (
        .clk     (clk),
        .we      (l1_we_s),
        .waddr   (caddr_wr[L1_AW-1:0]),
        .wdata   (cdata_wr),
        .raddr_a (caddr_rd[L1_AW-1:0]),
        .rdata_a (l1_rd_s),
        .raddr_b (dump_addr[L1_AW-1:0]),
        .rdata_b (l1_dump_s)
    );

    // Engine layer read mux; data is presented regardless of crd.
    always_comb begin
        case (csel)
            CSEL_L0: cdata_rd = l0_rd_s;
            CSEL_L1: cdata_rd = l1_rd_s;
            default: cdata_rd = {DW{1'b0}};
        endcase
    end

    // Dump readback mux, valid in every state.
    always_comb begin
        if (dump_sel) begin
            dump_data = l1_dump_s;
        end else begin
            dump_data = l0_dump_s;
        end
    end

    // Host sequencing: load -> armed (ready) -> run (count) -> done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= LOAD;
            busy_q_r <= 1'b0;
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
            wcnt0_r  <= {WCNT0_W{1'b0}};
            wcnt1_r  <= {WCNT1_W{1'b0}};
        end else begin
            busy_q_r <= busy;
            case (state_r)
                LOAD: begin
                    if (ld_last) begin
                        state_r <= ARMED;
                        ready_r <= 1'b1;
                    end
                end
                ARMED: begin
                    if (busy) begin
                        state_r <= RUN;
                        ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (l0_we_s && (wcnt0_r != WCNT0_MAX)) begin
                        wcnt0_r <= wcnt0_r + 13'd1;
                    end
                    if (l1_we_s && (wcnt1_r != WCNT1_MAX)) begin
                        wcnt1_r <= wcnt1_r + 11'd1;
                    end
                    // Falling edge of busy ends the run.
                    if (busy_q_r && !busy) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    if (ld_last) begin
                        state_r <= LOAD;
                        done_r  <= 1'b0;
                        wcnt0_r <= {WCNT0_W{1'b0}};
                        wcnt1_r <= {WCNT1_W{1'b0}};
                    end
                end
                default: begin
                    state_r <= LOAD;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign done  = done_r;
    assign wcnt0 = wcnt0_r;
    assign wcnt1 = wcnt1_r;

`ifdef CONV_HOST_ERRCHK_EN
    localparam logic [16:0] TMO_LIMIT = 17'h10000;

    logic        err_r;
    logic [16:0] tmo_cnt_r;
    logic        access_err_s;
    logic        tmo_err_s;

    // Illegal engine accesses: unmapped bank or out-of-range layer-1 address.
    always_comb begin
        if ((cwr || crd) && !csel_mapped(csel)) begin
            access_err_s = 1'b1;
        end else if (l1_we_s && (caddr_wr[IMG_AW-1:L1_AW] != 2'b00)) begin
            access_err_s = 1'b1;
        end else if (crd && (csel == CSEL_L1) && (caddr_rd[IMG_AW-1:L1_AW] != 2'b00)) begin
            access_err_s = 1'b1;
        end else begin
            access_err_s = 1'b0;
        end
    end

    // Start timeout once ready has been up for the full window.
    always_comb begin
        if ((state_r == ARMED) && !busy && (tmo_cnt_r == TMO_LIMIT)) begin
            tmo_err_s = 1'b1;
        end else begin
            tmo_err_s = 1'b0;
        end
    end

    // Ready-high cycle counter (saturating) and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= 17'd0;
            err_r     <= 1'b0;
        end else begin
            if ((state_r == ARMED) && ready_r) begin
                if (tmo_cnt_r != TMO_LIMIT) begin
                    tmo_cnt_r <= tmo_cnt_r + 17'd1;
                end
            end else begin
                tmo_cnt_r <= 17'd0;
            end
            if (access_err_s || tmo_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;
`else
    logic unused_crd_s;
    assign unused_crd_s = crd;
`endif

endmodule

// File: tb/tb_conv_layer_host.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_host
// Randomized, scoreboard-checked bench for conv_layer_host. Stimulus pushes
// expected observations into a queue; a negedge monitor pops and compares.
// The reference model is plain arrays plus run-level counters/flags.
// -----------------------------------------------------------------------------
module tb_conv_layer_host;

    localparam logic [2:0] C_L0 = 3'b001;
    localparam logic [2:0] C_L1 = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [19:0] ld_data;
    logic        ld_last;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        dump_sel;
    logic [11:0] dump_addr;
    logic [19:0] dump_data;
    logic        done;
    logic [12:0] wcnt0;
    logic [10:0] wcnt1;
`ifdef CONV_HOST_ERRCHK_EN
    logic        err;
`endif

    conv_layer_host dut (
        .clk       (clk),
        .reset     (reset),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .dump_sel  (dump_sel),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .done      (done),
        .wcnt0     (wcnt0),
        .wcnt1     (wcnt1)
`ifdef CONV_HOST_ERRCHK_EN
       ,.err       (err)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [19:0] img_m [4096];
    bit [19:0] l0_m  [4096];
    bit [19:0] l1_m  [1024];
    bit        ready_m, done_m, counting_m;
    int        n0_m, n1_m;

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    function automatic logic [19:0] model_rd(input logic [2:0] cs, input logic [11:0] a);
        if (cs == C_L0) return l0_m[a];
        else if (cs == C_L1) return l1_m[a[9:0]];
        else return 20'h0;
    endfunction

    task automatic model_wr(input logic [2:0] cs, input logic [11:0] a, input logic [19:0] d);
        if (cs == C_L0) begin
            l0_m[a] = d;
            if (counting_m) n0_m++;
        end else if (cs == C_L1) begin
            l1_m[a[9:0]] = d;
            if (counting_m) n1_m++;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef enum int {K_READY, K_DONE, K_WCNT0, K_WCNT1, K_IDATA, K_CRD, K_DUMP, K_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t chk_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input kind_t k, input string n, input logic [31:0] e);
        chk_t c;
        c.kind = k;
        c.name = n;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    chk_t        mon_c;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            mon_c = chk_q.pop_front();
            case (mon_c.kind)
                K_READY: mon_act = {31'd0, ready};
                K_DONE:  mon_act = {31'd0, done};
                K_WCNT0: mon_act = {19'd0, wcnt0};
                K_WCNT1: mon_act = {21'd0, wcnt1};
                K_IDATA: mon_act = {12'd0, idata};
                K_CRD:   mon_act = {12'd0, cdata_rd};
                K_DUMP:  mon_act = {12'd0, dump_data};
`ifdef CONV_HOST_ERRCHK_EN
                K_ERR:   mon_act = {31'd0, err};
`endif
                default: mon_act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (mon_act !== mon_c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", mon_c.name, mon_act, mon_c.exp, $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag);
        expect_val(K_READY, {tag, ".ready"}, {31'd0, ready_m});
        expect_val(K_DONE,  {tag, ".done"},  {31'd0, done_m});
        expect_val(K_WCNT0, {tag, ".wcnt0"}, sat(n0_m, 8191));
        expect_val(K_WCNT1, {tag, ".wcnt1"}, sat(n1_m, 2047));
    endtask

    task automatic do_wr(input logic [2:0] cs, input logic [11:0] a, input logic [19:0] d);
        cwr = 1'b1; csel = cs; caddr_wr = a; cdata_wr = d;
        step();
        cwr = 1'b0;
        model_wr(cs, a, d);
    endtask

    task automatic dump_chk(input string tag, input logic sel, input logic [11:0] a);
        dump_sel = sel; dump_addr = a;
        expect_val(K_DUMP, tag, {12'd0, sel ? l1_m[a[9:0]] : l0_m[a]});
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [2:0]  cs_tab [4];
    logic [2:0]  r_cs;
    logic [11:0] r_wa, r_ra;
    logic [19:0] r_d;
    logic        r_wr, r_rd;

    initial begin
        reset = 1'b1; busy = 1'b0; ld_we = 1'b0; ld_addr = 12'd0; ld_data = 20'd0;
        ld_last = 1'b0; iaddr = 12'd0; cwr = 1'b0; caddr_wr = 12'd0; cdata_wr = 20'd0;
        crd = 1'b0; caddr_rd = 12'd0; csel = 3'b000; dump_sel = 1'b0; dump_addr = 12'd0;
        ready_m = 1'b0; done_m = 1'b0; counting_m = 1'b0; n0_m = 0; n1_m = 0;
        cs_tab[0] = C_L0; cs_tab[1] = C_L1; cs_tab[2] = 3'b010; cs_tab[3] = 3'b111;

        repeat (2) step();
        status("reset");
        step();
        reset = 1'b0;

        // Layer writes in LOAD: stored but not counted.
        for (int a = 0; a < 4096; a++) do_wr(C_L0, a[11:0], 20'($urandom));
        for (int a = 0; a < 1024; a++) do_wr(C_L1, a[11:0], 20'($urandom));
        status("load_wr");
        dump_chk("load_dump0", 1'b0, 12'd77);
        dump_chk("load_dump1", 1'b1, 12'd900);

        // Image ramp, ld_last together with the final write.
        for (int a = 0; a < 4096; a++) begin
            ld_we = 1'b1; ld_addr = a[11:0]; ld_data = 20'(a);
            ld_last = (a == 4095);
            step();
            img_m[a] = 20'(a);
        end
        ld_we = 1'b0; ld_last = 1'b0;
        ready_m = 1'b1;
        status("armed");

        // Late patch while armed.
        r_d = 20'($urandom);
        ld_we = 1'b1; ld_addr = 12'd7; ld_data = r_d;
        step();
        ld_we = 1'b0; img_m[7] = r_d;

        busy = 1'b1;
        step();
        ready_m = 1'b0; counting_m = 1'b1;
        status("run");

        iaddr = 12'h041;
        expect_val(K_IDATA, "idata_41", 32'h0000_0041);
        step();
        iaddr = 12'hFFF;
        expect_val(K_IDATA, "idata_fff", {12'd0, img_m[4095]});
        step();
        iaddr = 12'd7;
        expect_val(K_IDATA, "idata_patch", {12'd0, img_m[7]});
        step();

        // Directed layer-0 write then read-back.
        do_wr(C_L0, 12'd100, 20'h01310);
        crd = 1'b1; csel = C_L0; caddr_rd = 12'd100;
        expect_val(K_CRD, "l0_rd100", 32'h0000_1310);
        status("l0_wr");
        step();
        crd = 1'b0;

        // Layer-1 write with high address bits set.
        do_wr(C_L1, 12'hC05, 20'h0ABCD);
        dump_sel = 1'b1; dump_addr = 12'd5;
        expect_val(K_DUMP, "l1_dump5", 32'h0000_ABCD);
        status("l1_wr");
`ifdef CONV_HOST_ERRCHK_EN
        expect_val(K_ERR, "err_l1hi", 32'd1);
`endif
        step();

        // Unmapped csel: dropped write, zero read.
        do_wr(3'b010, 12'd100, 20'($urandom));
        crd = 1'b1; csel = 3'b010; caddr_rd = 12'd100;
        expect_val(K_CRD, "unmapped_rd", 32'd0);
        status("unmapped");
        step();
        crd = 1'b0;
        dump_chk("unmapped_dump", 1'b0, 12'd100);

        // Randomized mixed traffic, including read-during-write collisions.
        for (int i = 0; i < 400; i++) begin
            r_cs = ($urandom_range(0, 4) == 0) ? 3'($urandom) : cs_tab[$urandom_range(0, 2)];
            r_wr = 1'($urandom); r_rd = 1'($urandom);
            r_wa = 12'($urandom); r_d = 20'($urandom);
            r_ra = ($urandom_range(0, 3) == 0) ? r_wa : 12'($urandom);
            if (r_cs == C_L1 && $urandom_range(0, 1) == 1) begin
                r_wa[11:10] = 2'b00; r_ra[11:10] = 2'b00;
            end
            cwr = r_wr; crd = r_rd; csel = r_cs;
            caddr_wr = r_wa; cdata_wr = r_d; caddr_rd = r_ra;
            dump_sel = 1'($urandom); dump_addr = 12'($urandom);
            if (r_rd) expect_val(K_CRD, "rand_rd", {12'd0, model_rd(r_cs, r_ra)});
            expect_val(K_DUMP, "rand_dump", {12'd0, dump_sel ? l1_m[dump_addr[9:0]] : l0_m[dump_addr]});
            step();
            if (r_wr) model_wr(r_cs, r_wa, r_d);
        end
        cwr = 1'b0; crd = 1'b0;
        status("rand_end");

        // Busy falls: done next cycle.
        busy = 1'b0;
        step();
        done_m = 1'b1; counting_m = 1'b0;
        status("done1");

        // Write in DONE: stored, not counted.
        do_wr(C_L0, 12'd5, 20'($urandom));
        status("done_wr");
        dump_chk("done_dump", 1'b0, 12'd5);

        // DONE -> LOAD clears, then re-arm.
        ld_last = 1'b1; step(); ld_last = 1'b0;
        done_m = 1'b0; n0_m = 0; n1_m = 0;
        status("reload");
        ld_last = 1'b1; step(); ld_last = 1'b0;
        ready_m = 1'b1;
        status("rearm");
        busy = 1'b1; step();
        ready_m = 1'b0; counting_m = 1'b1;

        // Full run, then push both counters into saturation.
        for (int a = 0; a < 4096; a++) do_wr(C_L0, a[11:0], 20'($urandom));
        status("full_l0");
        for (int a = 0; a < 1024; a++) do_wr(C_L1, a[11:0], 20'($urandom));
        status("full_l1");
        busy = 1'b0; step();
        done_m = 1'b1; counting_m = 1'b0;
        status("full_done");
        for (int i = 0; i < 8; i++) dump_chk("full_dump0", 1'b0, 12'($urandom));
        for (int i = 0; i < 8; i++) dump_chk("full_dump1", 1'b1, 12'($urandom));

        ld_last = 1'b1; step(); ld_last = 1'b0;
        done_m = 1'b0; n0_m = 0; n1_m = 0;
        ld_last = 1'b1; step(); ld_last = 1'b0;
        busy = 1'b1; step();
        counting_m = 1'b1;
        for (int i = 0; i < 8200; i++) do_wr(C_L0, 12'($urandom), 20'($urandom));
        for (int i = 0; i < 2060; i++) do_wr(C_L1, {2'b00, 10'($urandom)}, 20'($urandom));
        status("saturate");

        // Reset mid-run: status cleared, memories retained.
        reset = 1'b1; step(); reset = 1'b0;
        ready_m = 1'b0; done_m = 1'b0; n0_m = 0; n1_m = 0; counting_m = 1'b0;
        busy = 1'b0;
        status("reset_mid");
        for (int i = 0; i < 8; i++) dump_chk("rst_dump0", 1'b0, 12'($urandom));
        for (int i = 0; i < 8; i++) dump_chk("rst_dump1", 1'b1, 12'($urandom));
        iaddr = 12'd7;
        expect_val(K_IDATA, "rst_idata", {12'd0, img_m[7]});
        step();

        repeat (3) step();
        if (chk_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", chk_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
